// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined SECDED Hamming decoder with valid/ready handshake and
// saturating error statistics.
//
// Codeword layout: index i holds Hamming position i+1. Parity bits sit at the
// indices 2^k-1. Data bits fill the other indices below CW_W-1 in ascending
// order, LSB first. Index CW_W-1 holds the overall parity bit.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready/in_cw received codeword stream
//   out_valid/out_ready     decoded word stream
//   out_data                corrected data (raw data when uncorrectable)
//   out_single              single-bit error corrected
//   out_double              uncorrectable error detected
//   out_err_idx             codeword index that was corrected, 0 when none
//   cnt_clr                 synchronous clear of both counters
//   corr_cnt / uncorr_cnt   saturating counts of corrected / uncorrectable words
module hamming_secded_decoder #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CNT_W  = 16,
  // Smallest r with 2^r >= DATA_W + r + 1, for DATA_W in 1..57.
  localparam int unsigned PAR_W = (DATA_W <= 1)  ? 2 :
                                  (DATA_W <= 4)  ? 3 :
                                  (DATA_W <= 11) ? 4 :
                                  (DATA_W <= 26) ? 5 : 6,
  localparam int unsigned CW_W  = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_cw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_single,
  output logic              out_double,
  output logic [PAR_W:0]    out_err_idx,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  function automatic bit is_pow2(int unsigned v);
    return (v & (v - 1)) == 0;
  endfunction

  // Codeword index that carries data bit j.
  function automatic int unsigned data_pos(int unsigned j);
    int unsigned cnt;
    int unsigned pos;
    cnt = 0;
    pos = 0;
    for (int unsigned i = 0; i < CW_W - 1; i++) begin
      if (!is_pow2(i + 1)) begin
        if (cnt == j) pos = i;
        cnt++;
      end
    end
    return pos;
  endfunction

  // Handshake
  logic v1_q, v2_q;
  logic s1_adv, s2_adv;

  assign s2_adv   = !v2_q || out_ready;
  assign s1_adv   = !v1_q || s2_adv;
  assign in_ready = s1_adv;

  // Stage 1: data extraction, syndrome and overall check
  logic [DATA_W-1:0] dat_ext;
  logic [PAR_W-1:0]  syn_d;
  logic              par_d;
  logic [DATA_W-1:0] dat1_q;
  logic [PAR_W-1:0]  syn1_q;
  logic              par1_q;

  for (genvar j = 0; j < DATA_W; j++) begin : g_ext
    assign dat_ext[j] = in_cw[data_pos(j)];
  end

  always_comb begin
    syn_d = '0;
    for (int i = 0; i < CW_W - 1; i++) begin
      if (in_cw[i]) syn_d = syn_d ^ PAR_W'(i + 1);
    end
    par_d = ^in_cw;
  end

  // Payload only loads with a valid word so stale/undriven in_cw never reaches the flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      dat1_q <= '0;
      syn1_q <= '0;
      par1_q <= 1'b0;
    end else if (s1_adv) begin
      v1_q <= in_valid;
      if (in_valid) begin
        dat1_q <= dat_ext;
        syn1_q <= syn_d;
        par1_q <= par_d;
      end
    end
  end

  // Stage 2: classification and correction
  logic              in_range;
  logic              single_d, double_d;
  logic [PAR_W:0]    err_idx_d;
  logic [DATA_W-1:0] dat_fix;

  assign in_range = (syn1_q != '0) && ({1'b0, syn1_q} <= (PAR_W + 1)'(CW_W - 1));

  always_comb begin
    single_d  = 1'b0;
    double_d  = 1'b0;
    err_idx_d = '0;
    if (v1_q) begin
      if (par1_q) begin
        if (syn1_q == '0) begin
          // Only the overall parity bit flipped.
          single_d  = 1'b1;
          err_idx_d = (PAR_W + 1)'(CW_W - 1);
        end else if (in_range) begin
          single_d  = 1'b1;
          err_idx_d = {1'b0, syn1_q} - (PAR_W + 1)'(1);
        end else begin
          // Syndrome points past the codeword: cannot be a single error.
          double_d = 1'b1;
        end
      end else if (syn1_q != '0) begin
        double_d = 1'b1;
      end
    end
  end

  // Only a data bit whose position matches a correctable syndrome gets flipped.
  for (genvar j = 0; j < DATA_W; j++) begin : g_fix
    assign dat_fix[j] = dat1_q[j] ^
                        (par1_q && in_range && (syn1_q == PAR_W'(data_pos(j) + 1)));
  end

  logic [DATA_W-1:0] data_q;
  logic              single_q, double_q;
  logic [PAR_W:0]    err_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q      <= 1'b0;
      data_q    <= '0;
      single_q  <= 1'b0;
      double_q  <= 1'b0;
      err_idx_q <= '0;
    end else if (s2_adv) begin
      v2_q <= v1_q;
      if (v1_q) begin
        data_q    <= dat_fix;
        single_q  <= single_d;
        double_q  <= double_d;
        err_idx_q <= err_idx_d;
      end
    end
  end

  assign out_valid   = v2_q;
  assign out_data    = data_q;
  assign out_single  = single_q;
  assign out_double  = double_q;
  assign out_err_idx = err_idx_q;

  // Error counters: bump when a flagged word loads into stage 2; clear wins.
  logic [CNT_W-1:0] corr_cnt_q, uncorr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else if (cnt_clr) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else if (s2_adv) begin
      if (single_d && (corr_cnt_q != '1))   corr_cnt_q   <= corr_cnt_q + CNT_W'(1);
      if (double_d && (uncorr_cnt_q != '1)) uncorr_cnt_q <= uncorr_cnt_q + CNT_W'(1);
    end
  end

  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
module tb_hamming_secded_decoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_cw;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_single;
  logic       out_double;
  logic [3:0] out_err_idx;
  logic       cnt_clr;
  logic [15:0] corr_cnt;
  logic [15:0] uncorr_cnt;

  // Second instance with 2-bit counters shares all inputs, for saturation.
  logic       in_ready_s;
  logic       out_valid_s;
  logic [3:0] out_data_s;
  logic       out_single_s;
  logic       out_double_s;
  logic [3:0] out_err_idx_s;
  logic [1:0] corr_cnt_s;
  logic [1:0] uncorr_cnt_s;

  hamming_secded_decoder #(.DATA_W(4), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_cw       (in_cw),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_single  (out_single),
    .out_double  (out_double),
    .out_err_idx (out_err_idx),
    .cnt_clr     (cnt_clr),
    .corr_cnt    (corr_cnt),
    .uncorr_cnt  (uncorr_cnt)
  );

  hamming_secded_decoder #(.DATA_W(4), .CNT_W(2)) dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready_s),
    .in_cw       (in_cw),
    .out_valid   (out_valid_s),
    .out_ready   (out_ready),
    .out_data    (out_data_s),
    .out_single  (out_single_s),
    .out_double  (out_double_s),
    .out_err_idx (out_err_idx_s),
    .cnt_clr     (cnt_clr),
    .corr_cnt    (corr_cnt_s),
    .uncorr_cnt  (uncorr_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] data;
    logic       single;
    logic       dbl;
    logic [3:0] idx;
  } exp_t;

  typedef struct {
    logic [7:0] cw;
    exp_t       e;
    int         corr;
    int         unc;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  exp_t q[$];
  bit   hold_v = 1'b0;
  exp_t hold_snap;

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] enc(logic [3:0] d);
    logic [6:0] lo;
    lo = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    return {^lo, lo};
  endfunction

  // Nearest-codeword reference: distance 0 clean, 1 single, otherwise double.
  function automatic exp_t model(logic [7:0] cw);
    exp_t       r;
    logic [7:0] diff;
    r.data   = {cw[6], cw[5], cw[4], cw[2]};
    r.single = 1'b0;
    r.dbl    = 1'b1;
    r.idx    = 4'd0;
    for (int d = 0; d < 16; d++) begin
      diff = enc(4'(d)) ^ cw;
      if ($countones(diff) == 0) begin
        r.data = 4'(d);
        r.dbl  = 1'b0;
      end else if ($countones(diff) == 1) begin
        r.data   = 4'(d);
        r.dbl    = 1'b0;
        r.single = 1'b1;
        for (int b = 0; b < 8; b++) if (diff[b]) r.idx = 4'(b);
      end
    end
    return r;
  endfunction

  function automatic exp_t cur_out();
    exp_t c;
    c.data   = out_data;
    c.single = out_single;
    c.dbl    = out_double;
    c.idx    = out_err_idx;
    return c;
  endfunction

  // One streaming cycle: score handshakes at the negedge, advance past the posedge.
  task automatic step(output bit took);
    exp_t cur, e;
    took = 1'b0;
    @(negedge clk);
    cur = cur_out();
    check("in_ready", int'(in_ready), (q.size() == 2 && !out_ready) ? 0 : 1);
    if (hold_v) begin
      check("stall valid", int'(out_valid), 1);
      check("stall hold", int'(cur), int'(hold_snap));
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious out", int'(out_valid), 0);
      end else begin
        e = q.pop_front();
        check("stream word", int'(cur), int'(e));
        n_out++;
      end
    end
    hold_v    = out_valid && !out_ready;
    hold_snap = cur;
    if (in_valid && in_ready) begin
      q.push_back(model(in_cw));
      took = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vecs[10];
    bit         took;
    bit         seen;
    int         lat;
    int         guard;
    int         n_single, n_double, sent;
    exp_t       m;
    logic [3:0] pat;
    logic [7:0] words[8];

    vecs[0] = '{8'h55, '{4'hB, 1'b0, 1'b0, 4'd0}, 0, 0};
    vecs[1] = '{8'h45, '{4'hB, 1'b1, 1'b0, 4'd4}, 1, 0};
    vecs[2] = '{8'hD5, '{4'hB, 1'b1, 1'b0, 4'd7}, 2, 0};
    vecs[3] = '{8'h56, '{4'hB, 1'b0, 1'b1, 4'd0}, 2, 1};
    vecs[4] = '{8'h00, '{4'h0, 1'b0, 1'b0, 4'd0}, 2, 1};
    vecs[5] = '{8'hFF, '{4'hF, 1'b0, 1'b0, 4'd0}, 2, 1};
    vecs[6] = '{8'hBF, '{4'hF, 1'b1, 1'b0, 4'd6}, 3, 1};
    vecs[7] = '{8'hFC, '{4'hF, 1'b0, 1'b1, 4'd0}, 3, 2};
    vecs[8] = '{8'h01, '{4'h0, 1'b1, 1'b0, 4'd0}, 4, 2};
    vecs[9] = '{8'h3E, '{4'h3, 1'b1, 1'b0, 4'd5}, 5, 2};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_cw     = 8'h00;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", int'(out_valid), 0);
    check("rst in_ready", int'(in_ready), 1);
    check("rst out_data", int'(out_data), 0);
    check("rst err_idx", int'(out_err_idx), 0);
    check("rst corr_cnt", int'(corr_cnt), 0);
    check("rst uncorr_cnt", int'(uncorr_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, one word at a time
    for (int k = 0; k < 10; k++) begin
      in_cw    = vecs[k].cw;
      in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d in_ready", k), int'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_cw    = 8'($urandom);
      lat      = 0;
      seen     = 1'b0;
      for (int w = 0; w < 6 && !seen; w++) begin
        @(negedge clk);
        lat++;
        if (out_valid) seen = 1'b1;
      end
      check($sformatf("vec%0d latency", k), lat, 2);
      check($sformatf("vec%0d data", k), int'(out_data), int'(vecs[k].e.data));
      check($sformatf("vec%0d single", k), int'(out_single), int'(vecs[k].e.single));
      check($sformatf("vec%0d double", k), int'(out_double), int'(vecs[k].e.dbl));
      check($sformatf("vec%0d err_idx", k), int'(out_err_idx), int'(vecs[k].e.idx));
      check($sformatf("vec%0d corr_cnt", k), int'(corr_cnt), vecs[k].corr);
      check($sformatf("vec%0d uncorr_cnt", k), int'(uncorr_cnt), vecs[k].unc);
      check($sformatf("vec%0d sat corr", k), int'(corr_cnt_s),
            (vecs[k].corr > 3) ? 3 : vecs[k].corr);
      check($sformatf("vec%0d sat uncorr", k), int'(uncorr_cnt_s),
            (vecs[k].unc > 3) ? 3 : vecs[k].unc);
      @(posedge clk);
      #1;
    end

    // Clear on the same edge a single-error word enters stage 2
    in_cw    = 8'h45;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    check("clr out_valid", int'(out_valid), 1);
    check("clr out_single", int'(out_single), 1);
    check("clr corr_cnt", int'(corr_cnt), 0);
    check("clr uncorr_cnt", int'(uncorr_cnt), 0);
    check("clr sat corr", int'(corr_cnt_s), 0);
    @(posedge clk);
    #1;

    // Full sweep, back to back
    n_single = 0;
    n_double = 0;
    for (int c = 0; c < 256; c++) begin
      m = model(8'(c));
      if (m.single) n_single++;
      if (m.dbl) n_double++;
    end
    n_out = 0;
    for (int c = 0; c < 256; c++) begin
      in_cw    = 8'(c);
      in_valid = 1'b1;
      took     = 1'b0;
      guard    = 0;
      while (!took && guard < 20) begin
        step(took);
        guard++;
      end
    end
    in_valid = 1'b0;
    guard    = 0;
    while (q.size() > 0 && guard < 50) begin
      step(took);
      guard++;
    end
    check("sweep words out", n_out, 256);
    @(negedge clk);
    check("sweep corr_cnt", int'(corr_cnt), n_single);
    check("sweep uncorr_cnt", int'(uncorr_cnt), n_double);
    check("sweep sat corr", int'(corr_cnt_s), 3);
    check("sweep sat uncorr", int'(uncorr_cnt_s), 3);
    @(posedge clk);
    #1;

    // Backpressure: out_ready pattern 1,0,0,1 repeating
    words = '{8'h55, 8'h45, 8'hD5, 8'h56, 8'hBF, 8'hFC, 8'h3E, 8'h01};
    pat   = 4'b1001;
    sent  = 0;
    n_out = 0;
    for (int c = 0; c < 200 && !(sent == 8 && q.size() == 0); c++) begin
      out_ready = pat[c % 4];
      if (sent < 8) begin
        in_valid = 1'b1;
        in_cw    = words[sent];
      end else begin
        in_valid = 1'b0;
        in_cw    = 8'($urandom);
      end
      step(took);
      if (took) sent++;
    end
    check("bp words in", sent, 8);
    check("bp words out", n_out, 8);

    // Reset with two words in flight
    in_valid  = 1'b0;
    out_ready = 1'b0;
    hold_v    = 1'b0;
    in_cw     = 8'h45;
    in_valid  = 1'b1;
    step(took);
    in_cw = 8'h56;
    step(took);
    in_valid = 1'b0;
    check("mid in flight", q.size(), 2);
    rst_n = 1'b0;
    #1;
    check("mid rst out_valid", int'(out_valid), 0);
    check("mid rst in_ready", int'(in_ready), 1);
    check("mid rst corr_cnt", int'(corr_cnt), 0);
    check("mid rst uncorr_cnt", int'(uncorr_cnt), 0);
    check("mid rst single", int'(out_single), 0);
    check("mid rst double", int'(out_double), 0);
    q.delete();
    hold_v = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("no stale word", int'(out_valid), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
